// File: rtl/sram_data_responder.sv
// sram_data_responder
// Serves one 32-bit MEM-stage load or store from an external 16-bit SRAM as
// two half-word phases (low half first), each held for WAIT_CYCLES+1 cycles.
// `ready` is low for the whole access so the pipeline freezes. Load data is
// returned on read_data at the end of the DONE cycle.
//
// Ports:
//   clock, reset          : clock; synchronous active-low reset
//   mem_r_en, mem_w_en    : load / store request (a store wins if both are set)
//   address, write_data   : byte address and store value, latched on acceptance
//   read_data             : registered load result
//   ready                 : combinational; low while an access is in progress
//   sram_addr             : registered half-word address
//   sram_dq_out/_oe       : registered write data and bus drive enable
//   sram_dq_in            : SRAM read data
//   sram_we_n             : registered active-low write strobe
module sram_data_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned HALF_W  = 16;
  localparam int unsigned SRAM_AW = 18;
  localparam int unsigned WORD_W  = 17;
  localparam int unsigned CNT_W   = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                is_write, is_write_next;
  logic [WORD_W-1:0]   word, word_next;
  logic [DATA_W-1:0]   data, data_next;
  logic [DATA_W-1:0]   hold, hold_next;
  logic [DATA_W-1:0]   read_data_next;
  logic [SRAM_AW-1:0]  sram_addr_next;
  logic [HALF_W-1:0]   sram_dq_out_next;
  logic                sram_dq_oe_next;
  logic                sram_we_n_next;

  logic [WORD_W-1:0]   req_word;
  logic                req_valid;
  logic                phase_last;

  // Word index relative to BASE_ADDR; byte offset dropped, upper bits wrap.
  assign req_word   = WORD_W'((address - BASE_ADDR) >> 2);
  assign req_valid  = mem_r_en | mem_w_en;
  assign phase_last = (cnt == CNT_LAST);

  // A pending request in IDLE already reads as busy.
  assign ready = ((state == IDLE) && !req_valid) || (state == DONE);

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      is_write    <= 1'b0;
      word        <= '0;
      data        <= '0;
      hold        <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      is_write    <= is_write_next;
      word        <= word_next;
      data        <= data_next;
      hold        <= hold_next;
      read_data   <= read_data_next;
      sram_addr   <= sram_addr_next;
      sram_dq_out <= sram_dq_out_next;
      sram_dq_oe  <= sram_dq_oe_next;
      sram_we_n   <= sram_we_n_next;
    end
  end

  // Next state; SRAM pin values are set up one edge ahead so they are
  // registered and stable for every cycle of the phase they belong to.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    is_write_next    = is_write;
    word_next        = word;
    data_next        = data;
    hold_next        = hold;
    read_data_next   = read_data;
    sram_addr_next   = sram_addr;
    sram_dq_out_next = sram_dq_out;
    sram_dq_oe_next  = sram_dq_oe;
    sram_we_n_next   = sram_we_n;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_next      = LOW;
          cnt_next        = '0;
          is_write_next   = mem_w_en;
          word_next       = req_word;
          data_next       = write_data;
          sram_addr_next  = {req_word, 1'b0};
          sram_dq_oe_next = mem_w_en;
          sram_we_n_next  = !mem_w_en;
          if (mem_w_en) begin
            sram_dq_out_next = write_data[HALF_W-1:0];
          end
        end
      end

      LOW: begin
        if (phase_last) begin
          state_next     = HIGH;
          cnt_next       = '0;
          sram_addr_next = {word, 1'b1};
          if (is_write) begin
            sram_dq_out_next = data[DATA_W-1:HALF_W];
          end else begin
            hold_next[HALF_W-1:0] = sram_dq_in;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      HIGH: begin
        if (phase_last) begin
          state_next      = DONE;
          cnt_next        = '0;
          sram_dq_oe_next = 1'b0;
          sram_we_n_next  = 1'b1;
          if (!is_write) begin
            hold_next[DATA_W-1:HALF_W] = sram_dq_in;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      DONE: begin
        // Requests seen here wait until IDLE.
        state_next = IDLE;
        if (!is_write) begin
          read_data_next = hold;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_data_responder.sv
module tb_sram_data_responder;

  logic        clock;
  logic        reset;

  // W=1 instance
  logic        mem_r_en, mem_w_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  // W=0 instance
  logic        mem_r_en_b, mem_w_en_b;
  logic [31:0] address_b, write_data_b, read_data_b;
  logic        ready_b;
  logic [17:0] sram_addr_b;
  logic [15:0] sram_dq_out_b, sram_dq_in_b;
  logic        sram_dq_oe_b, sram_we_n_b;

  sram_data_responder #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) dut (
    .clock(clock), .reset(reset),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n)
  );

  sram_data_responder #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset),
    .mem_r_en(mem_r_en_b), .mem_w_en(mem_w_en_b),
    .address(address_b), .write_data(write_data_b),
    .read_data(read_data_b), .ready(ready_b),
    .sram_addr(sram_addr_b), .sram_dq_out(sram_dq_out_b),
    .sram_dq_oe(sram_dq_oe_b), .sram_dq_in(sram_dq_in_b),
    .sram_we_n(sram_we_n_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM pin model for the W=1 instance, with a backdoor preload port.
  logic [15:0] sram_mem [0:262143];
  logic        pre_en;
  logic [17:0] pre_addr;
  logic [15:0] pre_data;

  assign sram_dq_in = sram_mem[sram_addr];

  always @(posedge clock) begin
    if (pre_en) sram_mem[pre_addr] <= pre_data;
    else if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
  end

  // Fixed pattern memory for the W=0 instance.
  assign sram_dq_in_b = sram_addr_b[15:0] ^ 16'h5A5A;

  // Reference model: half-word contents and the expected read_data value.
  logic [15:0] ref_mem [int];
  int          wq[$];
  logic [31:0] exp_rd;

  int checks;
  int failures;

  logic [17:0] tr_addr[$];
  logic [15:0] tr_dq[$];
  logic        tr_we_n[$];
  logic        tr_oe[$];
  logic        done_we_n, done_oe;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [15:0] ref_rd(input int idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return 16'h0;
  endfunction

  task automatic ref_write(input logic [17:0] lo, input logic [31:0] d);
    ref_mem[int'(lo)]     = d[15:0];
    ref_mem[int'(lo) + 1] = d[31:16];
    wq.push_back(int'(lo) / 2);
  endtask

  // Issue one request on the W=1 instance and trace the busy cycles.
  task automatic run_txn(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lc, output bit to);
    tr_addr.delete(); tr_dq.delete(); tr_we_n.delete(); tr_oe.delete();
    lc = 0;
    to = 1'b0;
    mem_r_en = r; mem_w_en = w; address = a; write_data = d;
    @(negedge clock);
    while (ready !== 1'b1) begin
      lc++;
      if (lc > 1) begin
        tr_addr.push_back(sram_addr);
        tr_dq.push_back(sram_dq_out);
        tr_we_n.push_back(sram_we_n);
        tr_oe.push_back(sram_dq_oe);
      end
      if (lc > 40) begin
        to = 1'b1;
        break;
      end
      @(posedge clock); #1;
      mem_r_en = 1'b0; mem_w_en = 1'b0;
      address = $urandom; write_data = $urandom;
      @(negedge clock);
    end
    done_we_n = sram_we_n;
    done_oe   = sram_dq_oe;
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic check_txn(input string nm, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [17:0] lo, input logic [31:0] exp_rdata);
    int lc;
    bit to;
    logic [17:0] ea;
    run_txn(r, w, a, d, lc, to);
    chk({nm, ".timeout"}, 64'(to), 64'(0));
    chk({nm, ".ready_low_cycles"}, 64'(lc), 64'(5));
    chk({nm, ".trace_len"}, 64'(tr_addr.size()), 64'(4));
    if (tr_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        ea = (i < 2) ? lo : 18'(lo + 18'd1);
        chk({nm, ".sram_addr"}, 64'(tr_addr[i]), 64'(ea));
        chk({nm, ".we_n"}, 64'(tr_we_n[i]), 64'(!w));
        chk({nm, ".dq_oe"}, 64'(tr_oe[i]), 64'(w));
        if (w) chk({nm, ".dq_out"}, 64'(tr_dq[i]), (i < 2) ? 64'(d[15:0]) : 64'(d[31:16]));
      end
    end
    chk({nm, ".done_we_n"}, 64'(done_we_n), 64'(1));
    chk({nm, ".done_oe"}, 64'(done_oe), 64'(0));
    chk({nm, ".read_data"}, 64'(read_data), 64'(exp_rdata));
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
    logic [17:0] lo;
    logic [31:0] rdata;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[9];
    int   lc;
    int   strobes;
    logic [17:0] qa[$];
    logic [15:0] qd[$];
    logic        qw[$];

    checks = 0; failures = 0; exp_rd = 32'h0;
    reset = 1'b0;
    mem_r_en = 0; mem_w_en = 0; address = 0; write_data = 0;
    mem_r_en_b = 0; mem_w_en_b = 0; address_b = 0; write_data_b = 0;
    pre_en = 0; pre_addr = 0; pre_data = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("idle.ready", 64'(ready), 64'(1));
      chk("idle.we_n", 64'(sram_we_n), 64'(1));
      chk("idle.dq_oe", 64'(sram_dq_oe), 64'(0));
      chk("idle.read_data", 64'(read_data), 64'(0));
      chk("idle.sram_addr", 64'(sram_addr), 64'(0));
      chk("idle.dq_out", 64'(sram_dq_out), 64'(0));
    end
    chk("idle.ready_b", 64'(ready_b), 64'(1));
    @(posedge clock); #1;

    // Preload half-words 4 and 5
    pre_en = 1; pre_addr = 18'd4; pre_data = 16'h1234;
    @(posedge clock); #1;
    pre_addr = 18'd5; pre_data = 16'hABCD;
    @(posedge clock); #1;
    pre_en = 0;
    ref_mem[4] = 16'h1234; ref_mem[5] = 16'hABCD; wq.push_back(2);

    // Directed vectors
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 18'h00000, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0000_0000, 18'h00004, 32'hABCD_1234};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0404, 32'h0000_FFFF, 18'h00002, 32'hABCD_1234};
    vecs[3] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0000_0000, 18'h00002, 32'h0000_FFFF};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0402, 32'h0000_0000, 18'h00000, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0403, 32'h1122_3344, 18'h00000, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 18'h3FFFE, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 18'h3FFFE, 32'hCAFE_F00D};
    vecs[8] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 18'h00000, 32'h1122_3344};
    for (int i = 0; i < 9; i++) begin
      check_txn($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].addr,
                vecs[i].data, vecs[i].lo, vecs[i].rdata);
      if (vecs[i].w) ref_write(vecs[i].lo, vecs[i].data);
      exp_rd = vecs[i].rdata;
    end

    // Random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      bit          dow;
      int unsigned wd;
      logic [31:0] a, d, er;
      logic [17:0] lo;
      logic        r;
      dow = (wq.size() == 0) || ($urandom % 2 == 0);
      if (dow) wd = $urandom % 64;
      else     wd = int'(wq[$urandom % wq.size()]);
      a  = 32'(32'd1024 + wd * 4 + ($urandom % 4) + (($urandom % 4) << 19));
      d  = $urandom;
      lo = 18'(wd * 2);
      r  = dow ? 1'($urandom % 2) : 1'b1;
      er = dow ? exp_rd : {ref_rd(int'(lo) + 1), ref_rd(int'(lo))};
      check_txn($sformatf("rnd%0d", i), r, dow, a, d, lo, er);
      if (dow) ref_write(lo, d);
      exp_rd = er;
    end

    // SRAM contents against the model
    foreach (ref_mem[k]) chk($sformatf("mem[%0d]", k), 64'(sram_mem[18'(k)]), 64'(ref_mem[k]));

    // Reset during the second HIGH cycle of a store
    mem_w_en = 1; address = 32'h0000_0410; write_data = 32'h5566_7788;
    @(posedge clock); #1;
    mem_w_en = 0;
    repeat (3) begin @(posedge clock); #1; end
    chk("rst.high2_addr", 64'(sram_addr), 64'(9));
    chk("rst.high2_we_n", 64'(sram_we_n), 64'(0));
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst.ready", 64'(ready), 64'(1));
    chk("rst.we_n", 64'(sram_we_n), 64'(1));
    chk("rst.dq_oe", 64'(sram_dq_oe), 64'(0));
    chk("rst.read_data", 64'(read_data), 64'(0));
    chk("rst.sram_addr", 64'(sram_addr), 64'(0));
    chk("rst.dq_out", 64'(sram_dq_out), 64'(0));
    reset = 1'b1;
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (!sram_we_n || sram_dq_oe) strobes++;
    end
    chk("rst.no_strobes", 64'(strobes), 64'(0));
    chk("rst.low_half", 64'(sram_mem[18'd8]), 64'(16'h7788));
    @(posedge clock); #1;
    check_txn("post_rst", 1'b1, 1'b0, 32'h0000_03FC, 32'h0, 18'h3FFFE, 32'hCAFE_F00D);

    // W=0: wrapped load, then a store
    for (int t = 0; t < 2; t++) begin
      qa.delete(); qd.delete(); qw.delete();
      lc = 0;
      if (t == 0) begin
        mem_r_en_b = 1; address_b = 32'h0008_0400;
      end else begin
        mem_w_en_b = 1; address_b = 32'h0000_040C; write_data_b = 32'h1357_2468;
      end
      @(negedge clock);
      while (ready_b !== 1'b1 && lc < 20) begin
        lc++;
        if (lc > 1) begin
          qa.push_back(sram_addr_b); qd.push_back(sram_dq_out_b); qw.push_back(sram_we_n_b);
        end
        @(posedge clock); #1;
        mem_r_en_b = 0; mem_w_en_b = 0;
        @(negedge clock);
      end
      chk($sformatf("w0_%0d.ready_low_cycles", t), 64'(lc), 64'(3));
      chk($sformatf("w0_%0d.trace_len", t), 64'(qa.size()), 64'(2));
      if (qa.size() == 2) begin
        chk($sformatf("w0_%0d.addr_lo", t), 64'(qa[0]), (t == 0) ? 64'(0) : 64'(6));
        chk($sformatf("w0_%0d.addr_hi", t), 64'(qa[1]), (t == 0) ? 64'(1) : 64'(7));
        chk($sformatf("w0_%0d.we_n_lo", t), 64'(qw[0]), (t == 0) ? 64'(1) : 64'(0));
        chk($sformatf("w0_%0d.we_n_hi", t), 64'(qw[1]), (t == 0) ? 64'(1) : 64'(0));
        if (t == 1) begin
          chk("w0_1.dq_lo", 64'(qd[0]), 64'(16'h2468));
          chk("w0_1.dq_hi", 64'(qd[1]), 64'(16'h1357));
        end
      end
      @(posedge clock); #1;
      chk($sformatf("w0_%0d.read_data", t), 64'(read_data_b), 64'(32'h5A5B_5A5A));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_data_responder.md
Name: sram_data_responder

Overview:
Responder side of the MEM-stage data-memory interface. It accepts one 32-bit load or store request from the MEM stage and serves it from an external 16-bit-wide SRAM as two half-word accesses, with configurable wait states. It holds `ready` low for the whole access so the pipeline freezes, then returns load data. It sits between the MEM stage and the SRAM pins, in place of the on-chip data memory.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM half-word 0.
- WAIT_CYCLES, 1: extra cycles each half-word phase is held, range 0..7.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_r_en  in  1  load request from the MEM stage.
- mem_w_en  in  1  store request from the MEM stage.
- address  in  32  byte address (ALU result).
- write_data  in  32  store value.
- read_data  out  32  load result, registered.
- ready  out  1  high when no access is in progress; low freezes the pipeline.
- sram_addr  out  18  SRAM half-word address.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_oe  out  1  high: controller drives the DQ bus.
- sram_dq_in  in  16  SRAM read data.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-low.
- Reset (reset==0 at an edge):
  - state = IDLE, cycle counter = 0, read_data = 0.
  - sram_addr = 0, sram_dq_out = 0, sram_dq_oe = 0, sram_we_n = 1.
  - Reset aborts any access in progress; no further SRAM strobes are issued.
- Address mapping (combinational, captured on acceptance):
  - off = address - BASE_ADDR, 32-bit wrap-around arithmetic.
  - word = off[18:2]; off[1:0] is ignored (no misalignment fault).
  - low half-word address = {word, 1'b0}; high half-word address = {word, 1'b1}.
  - Bits above off[18] are discarded, so addresses wrap modulo 2^17 words.
- Request decode:
  - A request is sampled only in IDLE.
  - mem_w_en==1 means a write, whether or not mem_r_en is also 1 (write wins).
  - mem_r_en==1 alone means a read.
  - address, write_data and the request type are latched on acceptance. Input changes while busy are ignored.
- State machine IDLE -> LOW -> HIGH -> DONE -> IDLE:
  - IDLE: on a request, latch it, go to LOW, counter = 0. Otherwise stay.
  - LOW:
    - sram_addr = low address.
    - Write: sram_dq_out = data[15:0], sram_dq_oe = 1, sram_we_n = 0.
    - Read: sram_dq_oe = 0, sram_we_n = 1.
    - Stays WAIT_CYCLES+1 cycles. On the last cycle a read captures sram_dq_in into the low half of a holding register. Then go to HIGH, counter = 0.
  - HIGH: same as LOW, using the high address and data[31:16]; the last cycle captures the upper half. Then go to DONE.
  - DONE:
    - sram_we_n = 1, sram_dq_oe = 0.
    - Read: read_data = {upper, lower} at the end of this cycle.
    - Write: read_data is held unchanged.
    - Go to IDLE unconditionally; a request present during DONE is not accepted until IDLE.
- Outputs outside LOW/HIGH: sram_we_n = 1 and sram_dq_oe = 0. sram_addr and sram_dq_out hold their last values.
- ready (combinational):
  - ready = (state==IDLE && !mem_r_en && !mem_w_en) || state==DONE.
  - The request cycle itself shows ready = 0.
- Latency: ready is low for 2*WAIT_CYCLES+3 cycles, counting the acceptance cycle; it is high in DONE.
  - W=1: 5 cycles low.
  - W=0: 3 cycles low.
- read_data changes only on a read in DONE, or on reset.

Test Plan:
- Idle after reset, no requests -> ready=1, sram_we_n=1, sram_dq_oe=0, read_data=0 for 10 cycles.
- W=1, store address=0x400, data=0xDEADBEEF:
  - ready low for exactly 5 cycles.
  - sram_addr=0 with dq_out=0xBEEF and we_n=0 for 2 cycles, then sram_addr=1 with dq_out=0xDEAD for 2 cycles.
  - ready=1 in DONE.
- W=1, load address=0x408, SRAM model returns 0x1234 at half-word 4 and 0xABCD at half-word 5 -> sram_addr sequence 4,4,5,5, we_n=1 throughout, read_data=0xABCD1234 after DONE.
- mem_r_en=1 and mem_w_en=1 together at 0x404 with data 0x0000FFFF -> write at half-words 2 and 3; read_data unchanged.
- W=1, reset driven low during the second HIGH cycle of a store -> next edge gives state IDLE, we_n=1, dq_oe=0; the remaining half is not written.
- W=0, load at 0x400+4*2^17 -> wraps to sram_addr 0 then 1; ready low for 3 cycles.
